rtc_wr_ctrl: RTL

- Write-side controller for the external RTC multiplexed address/data bus.
- On a start pulse, it snapshots the seconds, minutes and hours values (BCD) from the edit/time registers.
- It then writes them to the RTC as three address-phase + data-phase bus cycles.
- It is the counterpart of the read path, where per-field capture registers latch data returned from the RTC.

---
 rtl/rtc_wr_ctrl_if.sv | 26 ++
 rtl/rtc_wr_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_wr_ctrl_if.sv
// Bus bundle between the RTC write controller and the rest of the system.
// master = controller side (drives the RTC bus), slave = system/bench side.
interface rtc_wr_ctrl_if;
    logic       start;
    logic [7:0] dseg;
    logic [7:0] dmin;
    logic [7:0] dhora;
    logic       busy;
    logic       done;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       a_d;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;

    modport master (
        input  start, dseg, dmin, dhora,
        output busy, done, ad_out, ad_oe, a_d, cs_n, wr_n, rd_n
    );

    modport slave (
        output start, dseg, dmin, dhora,
        input  busy, done, ad_out, ad_oe, a_d, cs_n, wr_n, rd_n
    );
endinterface

// File: rtl/rtc_wr_ctrl.sv
// Write-side controller for the RTC multiplexed address/data bus: snapshots sec/min/hour
// and issues address+data write phases. Define RTC_TRANSFER_EN to add the 0xF1 transfer phase.
module rtc_wr_ctrl #(
    parameter int unsigned T_SU      = 2,
    parameter int unsigned T_PW      = 4,
    parameter int unsigned T_HD      = 2,
    parameter int unsigned T_GAP     = 2,
    parameter logic [7:0]  ADDR_SEC  = 8'h21,
    parameter logic [7:0]  ADDR_MIN  = 8'h22,
    parameter logic [7:0]  ADDR_HOUR = 8'h23
) (
    input  logic         clk,
    input  logic         reset,
    rtc_wr_ctrl_if.master bus
);

    localparam int unsigned T_MAX_A = (T_SU > T_PW) ? T_SU : T_PW;
    localparam int unsigned T_MAX_B = (T_HD > T_GAP) ? T_HD : T_GAP;
    localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // Counter holds remaining cycles minus one, so each state loads T-1.
    localparam logic [CNT_W-1:0] LD_SU  = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] LD_PW  = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] LD_HD  = CNT_W'(T_HD - 1);
    localparam logic [CNT_W-1:0] LD_GAP = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

`ifdef RTC_TRANSFER_EN
    localparam logic [7:0] ADDR_XFER = 8'hF1;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [1:0]       field_q, field_d;
    logic [7:0]       snap_sec_q, snap_sec_d;
    logic [7:0]       snap_min_q, snap_min_d;
    logic [7:0]       snap_hour_q, snap_hour_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       ad_out_q, ad_out_d;
    logic             ad_oe_q, ad_oe_d;
    logic             a_d_q, a_d_d;
    logic             cs_n_q, cs_n_d;
    logic             wr_n_q, wr_n_d;

    logic             last_phase;
    logic [7:0]       field_addr;
    logic [7:0]       field_data;

`ifdef RTC_TRANSFER_EN
    // Field 3 is the address-only transfer command that follows the hours data phase.
    assign last_phase = (field_q == 2'd3);
`else
    assign last_phase = (field_q == 2'd2) && phase_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        field_d     = field_q;
        snap_sec_d  = snap_sec_q;
        snap_min_d  = snap_min_q;
        snap_hour_d = snap_hour_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_SETUP;
                    cnt_d       = LD_SU;
                    phase_d     = 1'b0;
                    field_d     = 2'd0;
                    snap_sec_d  = bus.dseg;
                    snap_min_d  = bus.dmin;
                    snap_hour_d = bus.dhora;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = LD_PW;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = LD_HD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = LD_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (last_phase) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETUP;
                    cnt_d   = LD_SU;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        field_d = field_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        field_addr = ADDR_SEC;
        field_data = snap_sec_q;
        case (field_d)
            2'd1: begin
                field_addr = ADDR_MIN;
                field_data = snap_min_q;
            end
            2'd2: begin
                field_addr = ADDR_HOUR;
                field_data = snap_hour_q;
            end
`ifdef RTC_TRANSFER_EN
            2'd3: begin
                field_addr = ADDR_XFER;
            end
`endif
            default: ;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        busy_d   = (state_d == ST_SETUP) || (state_d == ST_PULSE) ||
                   (state_d == ST_HOLD)  || (state_d == ST_GAP);
        done_d   = (state_d == ST_DONE);
        cs_n_d   = !((state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD));
        wr_n_d   = (state_d != ST_PULSE);
        ad_oe_d  = !cs_n_d;
        a_d_d    = a_d_q;
        ad_out_d = ad_out_q;
        // Bus contents only move on SETUP entry, while cs_n is still high from GAP/IDLE.
        if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) begin
            a_d_d    = phase_d;
            ad_out_d = phase_d ? field_data : field_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            field_q     <= 2'd0;
            snap_sec_q  <= 8'h00;
            snap_min_q  <= 8'h00;
            snap_hour_q <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ad_out_q    <= 8'h00;
            ad_oe_q     <= 1'b0;
            a_d_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            field_q     <= field_d;
            snap_sec_q  <= snap_sec_d;
            snap_min_q  <= snap_min_d;
            snap_hour_q <= snap_hour_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ad_out_q    <= ad_out_d;
            ad_oe_q     <= ad_oe_d;
            a_d_q       <= a_d_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.ad_out = ad_out_q;
    assign bus.ad_oe  = ad_oe_q;
    assign bus.a_d    = a_d_q;
    assign bus.cs_n   = cs_n_q;
    assign bus.wr_n   = wr_n_q;
    assign bus.rd_n   = 1'b1;

endmodule
